// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: multi-cycle multiply/divide sequencer that sits beside the
// EXE-stage ALU and owns the HI/LO registers. EXE holds the op stable and
// stalls on done; multiply finishes after MUL_LAT cycles, divide runs a
// restoring 1-bit/cycle loop followed by one sign-fix cycle.
module exe_muldiv_ctrl #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            advance,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    logic [2:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] op_a;       // multiplicand
    logic [XLEN-1:0] op_b;       // multiplier, or |divisor|
    logic            op_signed;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;        // starts as |dividend|, shifts into quotient

    // request decode; op[0]==0 marks the signed flavour of MULT/DIV
    logic            is_mul, is_div, is_mt, req_signed;
    logic [XLEN-1:0] abs_a, abs_b;

    // operand decode and absolute values for signed divide
    always_comb begin
        is_mul     = (req_op[2:1] == 2'b00);
        is_div     = (req_op[2:1] == 2'b01);
        is_mt      = req_op[2];
        req_signed = ~req_op[0];
        abs_a      = (req_signed && src_a[XLEN-1]) ? -src_a : src_a;
        abs_b      = (req_signed && src_b[XLEN-1]) ? -src_b : src_b;
    end

    // product of the latched operands; low 2*XLEN bits of the sign-extended
    // product are exact for both signed and unsigned multiply
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext;

    // sign/zero extension and multiply
    always_comb begin
        mul_a_ext = {{XLEN{op_signed & op_a[XLEN-1]}}, op_a};
        mul_b_ext = {{XLEN{op_signed & op_b[XLEN-1]}}, op_b};
        prod      = mul_a_ext * mul_b_ext;
    end

    // one restoring-divide step; rem < divisor always holds, so the shifted
    // remainder fits in XLEN+1 bits and bit XLEN of the difference is its sign.
    // With a zero divisor every step succeeds, giving an all-ones quotient and
    // the dividend as remainder.
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_n, quo_n;

    // divide step datapath
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, op_b};
        if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[XLEN-1:0];
            quo_n = {quo[XLEN-2:0], 1'b0};
        end
    end

    // sign fix: quotient negated when signs differ (skipped for divide by zero
    // so lo stays all-ones); remainder follows the dividend sign, which also
    // returns the raw dividend for divide by zero
    logic [XLEN-1:0] quo_fix, rem_fix;

    // final divide result correction
    always_comb begin
        quo_fix = (op_signed && (sign_a ^ sign_b) && !div_zero) ? -quo : quo;
        rem_fix = (op_signed && sign_a) ? -rem : rem;
    end

    // MT/no-op requests complete in IDLE without a state change
    assign done = (state == S_DONE) || ((state == S_IDLE) && req_valid && is_mt);
    assign busy = (state != S_IDLE);

    // sequencer state, operand capture and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            rem       <= '0;
            quo       <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (is_mul) begin
                            op_a      <= src_a;
                            op_b      <= src_b;
                            op_signed <= req_signed;
                            cnt       <= CW'(MUL_LAT - 1);
                            state     <= S_MUL;
                        end else if (is_div) begin
                            quo       <= abs_a;
                            op_b      <= abs_b;
                            rem       <= '0;
                            op_signed <= req_signed;
                            sign_a    <= src_a[XLEN-1];
                            sign_b    <= src_b[XLEN-1];
                            div_zero  <= (src_b == '0);
                            cnt       <= CW'(XLEN - 1);
                            state     <= S_DIV;
                        end else if (advance) begin
                            if (req_op == 3'b100) hi <= src_a;
                            if (req_op == 3'b101) lo <= src_a;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= prod;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    if (cnt == '0) state <= S_FIX;
                    else           cnt   <= cnt - CW'(1);
                end
                S_FIX: begin
                    lo    <= quo_fix;
                    hi    <= rem_fix;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // the instruction still presenting req_valid is the one leaving
                    if (advance) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
